// File: rtl/conv_stream_arbiter_if.sv
// Stream bundle between the arbiter, its two requester channels and the shared convolution engine.
// master = arbiter side, slave = channels plus engine side.
interface conv_stream_arbiter_if #(
    parameter int unsigned T = 16
);
    logic [T-1:0] x0_data;
    logic         x0_valid;
    logic         x0_ready;
    logic [T-1:0] x1_data;
    logic         x1_valid;
    logic         x1_ready;

    logic [T-1:0] y0_data;
    logic         y0_valid;
    logic         y0_ready;
    logic [T-1:0] y1_data;
    logic         y1_valid;
    logic         y1_ready;

    logic [T-1:0] e_x_data;
    logic         e_x_valid;
    logic         e_x_ready;
    logic [T-1:0] e_y_data;
    logic         e_y_valid;
    logic         e_y_ready;

    modport master (
        input  x0_data, x0_valid, x1_data, x1_valid,
        input  y0_ready, y1_ready,
        input  e_x_ready, e_y_data, e_y_valid,
        output x0_ready, x1_ready,
        output y0_data, y0_valid, y1_data, y1_valid,
        output e_x_data, e_x_valid, e_y_ready
    );

    modport slave (
        output x0_data, x0_valid, x1_data, x1_valid,
        output y0_ready, y1_ready,
        output e_x_ready, e_y_data, e_y_valid,
        input  x0_ready, x1_ready,
        input  y0_data, y0_valid, y1_data, y1_valid,
        input  e_x_data, e_x_valid, e_y_ready
    );
endinterface

// File: rtl/conv_stream_arbiter.sv
// Round-robin arbiter sharing one convolution engine between two stream channels.
// A job loads N samples from the owner, then returns all L = N-M+1 results before re-arbitrating.
module conv_stream_arbiter #(
    parameter int unsigned N = 32,
    parameter int unsigned M = 6,
    parameter int unsigned T = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    conv_stream_arbiter_if.master bus,
    output logic [1:0]            grant,
    output logic                  busy
);
    localparam int unsigned L   = N - M + 1;
    localparam int unsigned XCW = $clog2(N + 1);
    localparam int unsigned YCW = $clog2(L + 1);
    localparam logic [T-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     grant_d;
    logic           busy_d;
    logic           last_q, last_d;
    logic [XCW-1:0] x_cnt_q, x_cnt_d;
    logic [YCW-1:0] y_cnt_q, y_cnt_d;
    logic           x_fire;
    logic           y_fire;

    // State, ownership and job counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant   <= 2'b00;
            busy    <= 1'b0;
            last_q  <= 1'b1;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            busy    <= busy_d;
            last_q  <= last_d;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
        end
    end

    // Combinational stream routing; everything not owned is held at zero
    always_comb begin
        bus.x0_ready  = 1'b0;
        bus.x1_ready  = 1'b0;
        bus.y0_data   = ZERO;
        bus.y0_valid  = 1'b0;
        bus.y1_data   = ZERO;
        bus.y1_valid  = 1'b0;
        bus.e_x_data  = ZERO;
        bus.e_x_valid = 1'b0;
        bus.e_y_ready = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (grant[1]) begin
                    bus.e_x_data  = bus.x1_data;
                    bus.e_x_valid = bus.x1_valid;
                    bus.x1_ready  = bus.e_x_ready;
                end else begin
                    bus.e_x_data  = bus.x0_data;
                    bus.e_x_valid = bus.x0_valid;
                    bus.x0_ready  = bus.e_x_ready;
                end
            end
            S_DRAIN: begin
                if (grant[1]) begin
                    bus.y1_data   = bus.e_y_data;
                    bus.y1_valid  = bus.e_y_valid;
                    bus.e_y_ready = bus.y1_ready;
                end else begin
                    bus.y0_data   = bus.e_y_data;
                    bus.y0_valid  = bus.e_y_valid;
                    bus.e_y_ready = bus.y0_ready;
                end
            end
            default: ;
        endcase
    end

    assign x_fire = (state_q == S_LOAD)  && bus.e_x_valid && bus.e_x_ready;
    assign y_fire = (state_q == S_DRAIN) && bus.e_y_valid && bus.e_y_ready;

    // Next-state: arbitration in IDLE, count-driven phase changes otherwise
    always_comb begin
        state_d = state_q;
        grant_d = grant;
        last_d  = last_q;
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.x0_valid || bus.x1_valid) begin
                    if (bus.x0_valid && bus.x1_valid) begin
                        grant_d = last_q ? 2'b01 : 2'b10;
                    end else begin
                        grant_d = bus.x1_valid ? 2'b10 : 2'b01;
                    end
                    x_cnt_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (x_fire) begin
                    x_cnt_d = x_cnt_q + XCW'(1);
                    if (x_cnt_q == XCW'(N - 1)) begin
                        y_cnt_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (y_fire) begin
                    y_cnt_d = y_cnt_q + YCW'(1);
                    if (y_cnt_q == YCW'(L - 1)) begin
                        last_d  = grant[1];
                        grant_d = 2'b00;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_conv_stream_arbiter.sv
// Directed bench for conv_stream_arbiter with a small moving-sum engine model (all taps 1),
// so result k of a job whose samples are base+i is 6*base + 6*k + 15.
`timescale 1ns/1ps
module tb_conv_stream_arbiter;
    localparam int unsigned N = 32;
    localparam int unsigned M = 6;
    localparam int unsigned T = 16;
    localparam int unsigned L = N - M + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant;
    logic       busy;

    conv_stream_arbiter_if #(.T(T)) bus ();

    conv_stream_arbiter #(.N(N), .M(M), .T(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Engine model: accepts N samples, then offers L windowed sums
    logic [T-1:0] eng_mem [N];
    logic [4:0]   eng_in, eng_out;
    logic         eng_phase;
    logic [T-1:0] eng_sum;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_in    <= '0;
            eng_out   <= '0;
            eng_phase <= 1'b0;
        end else if (!eng_phase) begin
            if (bus.e_x_valid && bus.e_x_ready) begin
                eng_mem[eng_in] <= bus.e_x_data;
                if (eng_in == 5'(N - 1)) begin
                    eng_in    <= '0;
                    eng_out   <= '0;
                    eng_phase <= 1'b1;
                end else begin
                    eng_in <= eng_in + 5'd1;
                end
            end
        end else if (bus.e_y_valid && bus.e_y_ready) begin
            if (eng_out == 5'(L - 1)) eng_phase <= 1'b0;
            else                      eng_out   <= eng_out + 5'd1;
        end
    end

    always_comb begin
        eng_sum = '0;
        for (int j = 0; j < int'(M); j++) eng_sum = eng_sum + eng_mem[eng_out + 5'(j)];
    end

    assign bus.e_x_ready = !eng_phase;
    assign bus.e_y_valid = eng_phase;
    assign bus.e_y_data  = eng_sum;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   x_hs, y_hs0, y_hs1, y_idx0, y_idx1, y1_seen, first_xr1;
    int   base0_q[$], base1_q[$], grant_log[$], start_cyc[$], end_cyc[$];
    logic [1:0] prev_grant;
    bit   abort_tx;

    function automatic int qget(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    // Negedge monitor: routing checks every cycle, result data on every handshake
    initial begin
        int exp_xd, exp_y0d, exp_y1d, b;
        logic ph;
        logic [1:0] g;
        forever begin
            @(negedge clk);
            if (reset) begin
                y_idx0 = 0; y_idx1 = 0; prev_grant = 2'b00;
            end else begin
                g  = grant;
                ph = eng_phase;
                check_eq("x0_ready", int'(bus.x0_ready), int'(g == 2'b01 && bus.e_x_ready));
                check_eq("x1_ready", int'(bus.x1_ready), int'(g == 2'b10 && bus.e_x_ready));
                check_eq("e_x_valid", int'(bus.e_x_valid),
                         int'(!ph && ((g == 2'b01 && bus.x0_valid) || (g == 2'b10 && bus.x1_valid))));
                exp_xd = (!ph && g == 2'b01) ? int'(bus.x0_data) :
                         (!ph && g == 2'b10) ? int'(bus.x1_data) : 0;
                check_eq("e_x_data", int'(bus.e_x_data), exp_xd);
                check_eq("e_y_ready", int'(bus.e_y_ready),
                         int'(ph && ((g == 2'b01 && bus.y0_ready) || (g == 2'b10 && bus.y1_ready))));
                check_eq("y0_valid", int'(bus.y0_valid), int'(ph && g == 2'b01));
                check_eq("y1_valid", int'(bus.y1_valid), int'(ph && g == 2'b10));
                exp_y0d = (ph && g == 2'b01) ? int'(bus.e_y_data) : 0;
                exp_y1d = (ph && g == 2'b10) ? int'(bus.e_y_data) : 0;
                check_eq("y0_route", int'(bus.y0_data), exp_y0d);
                check_eq("y1_route", int'(bus.y1_data), exp_y1d);

                if (bus.e_x_valid && bus.e_x_ready) x_hs++;
                if (bus.y1_valid) y1_seen++;
                if (bus.y0_valid && bus.y0_ready) begin
                    b = (base0_q.size() > 0) ? base0_q[0] : 0;
                    check_eq("y0_result", int'(bus.y0_data), int'(16'(6 * b + 6 * y_idx0 + 15)));
                    y_hs0++; y_idx0++;
                    if (y_idx0 == int'(L)) begin
                        y_idx0 = 0;
                        end_cyc.push_back(cyc);
                        if (base0_q.size() > 0) void'(base0_q.pop_front());
                    end
                end
                if (bus.y1_valid && bus.y1_ready) begin
                    b = (base1_q.size() > 0) ? base1_q[0] : 0;
                    check_eq("y1_result", int'(bus.y1_data), int'(16'(6 * b + 6 * y_idx1 + 15)));
                    y_hs1++; y_idx1++;
                    if (y_idx1 == int'(L)) begin
                        y_idx1 = 0;
                        end_cyc.push_back(cyc);
                        if (base1_q.size() > 0) void'(base1_q.pop_front());
                    end
                end
                if (g != 2'b00 && prev_grant == 2'b00) begin
                    grant_log.push_back(int'(g));
                    start_cyc.push_back(cyc);
                end
                if (bus.x1_ready && first_xr1 < 0) first_xr1 = cyc;
                prev_grant = g;
            end
        end
    end

    task automatic clear_logs();
        x_hs = 0; y_hs0 = 0; y_hs1 = 0; y1_seen = 0; first_xr1 = -1;
        grant_log.delete(); start_cyc.delete(); end_cyc.delete();
    endtask

    task automatic send_job(input int ch, input int base, input bit bubbles);
        int i = 0;
        int guard = 0;
        bit vld, rdy;
        while (i < int'(N) && guard < 3000) begin
            @(posedge clk); #1;
            vld = !(bubbles && $urandom_range(0, 1) == 0);
            if (ch == 0) begin bus.x0_valid = vld; bus.x0_data = T'(base + i); end
            else         begin bus.x1_valid = vld; bus.x1_data = T'(base + i); end
            @(negedge clk);
            rdy = (ch == 0) ? bus.x0_ready : bus.x1_ready;
            if (vld && rdy) i++;
            guard++;
            if (abort_tx) break;
        end
        @(posedge clk); #1;
        if (ch == 0) bus.x0_valid = 1'b0;
        else         bus.x1_valid = 1'b0;
        if (!abort_tx) check_eq("send_done", i, int'(N));
    endtask

    task automatic wait_ends(input int n, input string tag);
        for (int i = 0; i < 4000 && end_cyc.size() < n; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check_eq(tag, end_cyc.size(), n);
    endtask

    task automatic check_eng_order(input int base, input string tag);
        int bad = 0;
        for (int i = 0; i < int'(N); i++) if (eng_mem[5'(i)] !== T'(base + i)) bad++;
        check_eq(tag, bad, 0);
    endtask

    initial begin
        bus.x0_valid = 1'b0; bus.x0_data = '0;
        bus.x1_valid = 1'b0; bus.x1_data = '0;
        bus.y0_ready = 1'b0; bus.y1_ready = 1'b0;
        abort_tx = 1'b0;
        clear_logs();

        // Reset values
        repeat (2) @(posedge clk); #1;
        check_eq("rst_grant", int'(grant), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_x0_ready", int'(bus.x0_ready), 0);
        check_eq("rst_y0_valid", int'(bus.y0_valid), 0);
        check_eq("rst_e_x_valid", int'(bus.e_x_valid), 0);
        check_eq("rst_e_y_ready", int'(bus.e_y_ready), 0);
        check_eq("rst_e_x_data", int'(bus.e_x_data), 0);
        @(negedge clk);
        reset = 1'b0;
        bus.y0_ready = 1'b1; bus.y1_ready = 1'b1;

        // Both channels request from reset: ch0, ch1, ch0
        clear_logs();
        base0_q = '{0, 200}; base1_q = '{100};
        fork
            begin send_job(0, 0, 1'b0); send_job(0, 200, 1'b0); end
            send_job(1, 100, 1'b0);
        join
        wait_ends(3, "rr_done");
        check_eq("rr_grant0", qget(grant_log, 0), 1);
        check_eq("rr_grant1", qget(grant_log, 1), 2);
        check_eq("rr_grant2", qget(grant_log, 2), 1);
        check_eq("rr_gap1", qget(start_cyc, 1) - qget(end_cyc, 0), 2);
        check_eq("rr_gap2", qget(start_cyc, 2) - qget(end_cyc, 1), 2);
        check_eq("rr_x1_first_ready", first_xr1, qget(start_cyc, 1));
        check_eq("rr_y0_count", y_hs0, 2 * int'(L));
        check_eq("rr_y1_count", y_hs1, int'(L));
        check_eq("rr_x_count", x_hs, 3 * int'(N));

        // ch0 alone, samples 0..31
        clear_logs();
        base0_q = '{0};
        send_job(0, 0, 1'b0);
        wait_ends(1, "solo_done");
        check_eng_order(0, "solo_eng_order");
        check_eq("solo_x_count", x_hs, int'(N));
        check_eq("solo_y0_count", y_hs0, int'(L));
        check_eq("solo_y1_valid_seen", y1_seen, 0);
        @(negedge clk);
        check_eq("solo_grant_idle", int'(grant), 0);
        check_eq("solo_busy_idle", int'(busy), 0);

        // y0_ready toggling through the drain
        clear_logs();
        base0_q = '{500};
        send_job(0, 500, 1'b0);
        for (int i = 0; i < 400 && end_cyc.size() < 1; i++) begin
            @(posedge clk); #1;
            bus.y0_ready = ~bus.y0_ready;
        end
        bus.y0_ready = 1'b1;
        wait_ends(1, "toggle_done");
        check_eq("toggle_y0_count", y_hs0, int'(L));

        // Random input bubbles
        clear_logs();
        base0_q = '{1000};
        send_job(0, 1000, 1'b1);
        wait_ends(1, "bubble_done");
        check_eng_order(1000, "bubble_eng_order");
        check_eq("bubble_x_count", x_hs, int'(N));
        check_eq("bubble_y0_count", y_hs0, int'(L));

        // ch1 requests while ch0 drains
        clear_logs();
        base0_q = '{300}; base1_q = '{400};
        fork
            send_job(0, 300, 1'b0);
            begin
                for (int i = 0; i < 500 && !eng_phase; i++) @(posedge clk);
                send_job(1, 400, 1'b0);
            end
        join
        wait_ends(2, "late_done");
        check_eq("late_grant0", qget(grant_log, 0), 1);
        check_eq("late_grant1", qget(grant_log, 1), 2);
        check_eq("late_gap", qget(start_cyc, 1) - qget(end_cyc, 0), 2);
        check_eq("late_x1_first_ready", first_xr1, qget(start_cyc, 1));
        check_eq("late_y1_count", y_hs1, int'(L));

        // Asynchronous reset after 10 samples, then a fresh job
        clear_logs();
        base0_q.delete();
        fork
            send_job(0, 700, 1'b0);
            begin
                for (int i = 0; i < 500 && x_hs < 10; i++) @(posedge clk);
                check_eq("pre_reset_x_count", x_hs, 10);
                #3 reset = 1'b1;
                #1;
                check_eq("mid_rst_grant", int'(grant), 0);
                check_eq("mid_rst_x0_ready", int'(bus.x0_ready), 0);
                check_eq("mid_rst_busy", int'(busy), 0);
                check_eq("mid_rst_e_x_valid", int'(bus.e_x_valid), 0);
                abort_tx = 1'b1;
                repeat (2) @(posedge clk);
                #3 reset = 1'b0;
            end
        join
        abort_tx = 1'b0;
        clear_logs();
        base0_q = '{700};
        send_job(0, 700, 1'b0);
        wait_ends(1, "post_rst_done");
        check_eng_order(700, "post_rst_eng_order");
        check_eq("post_rst_x_count", x_hs, int'(N));
        check_eq("post_rst_y0_count", y_hs0, int'(L));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end
endmodule
